// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, sequencer state encoding and operand digit check.
package bcd_pkg;
    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_RECOMP, S_DONE} state_e;
    function automatic logic bcd_vec_valid(input logic [63:0] vec, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (i < ndig && vec[4*i +: 4] > BCD_MAX) ok = 1'b0;
        return ok;
    endfunction
endpackage

// File: rtl/bcd_serial_addsub_ctrl.sv
// bcd_serial_addsub_ctrl: digit-serial BCD add/subtract sequencer driving an external
// ten's-complement digit adder, LSD first, with recomplement of negative differences.
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIG_W*NDIG-1:0] in_a,
    input  logic [DIG_W*NDIG-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIG_W*NDIG-1:0] out_sum,
    output logic                  out_neg,
    output logic                  out_ovf,
    output logic                  out_err,
    output logic [DIG_W-1:0]      da_dig_a,
    output logic [DIG_W-1:0]      da_dig_b,
    output logic                  da_sub,
    output logic                  da_cin,
    input  logic [DIG_W-1:0]      da_sum,
    input  logic                  da_cout
);
    localparam int W  = DIG_W * NDIG;
    localparam int IW = $clog2(NDIG);
    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           sub_q, sub_d, carry_q, carry_d;
    logic           neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
    logic           last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end
    assign last = idx_q == IW'(NDIG - 1);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                sub_d   = in_sub;
                carry_d = in_sub;
                idx_d   = '0;
                res_d   = '0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
                err_d   = !(bcd_vec_valid(64'(in_a), NDIG) && bcd_vec_valid(64'(in_b), NDIG));
                state_d = err_d ? S_DONE : S_ADD;
            end
            S_ADD: begin
                res_d   = {da_sum, res_q[W-1:DIG_W]};
                a_d     = a_q >> DIG_W;
                b_d     = b_q >> DIG_W;
                carry_d = da_cout;
                idx_d   = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    ovf_d   = !sub_q && da_cout;
                    neg_d   = sub_q && !da_cout;
                    // recomplement pass starts with carry-in 1 to form 0 - result
                    carry_d = neg_d ? 1'b1 : da_cout;
                    state_d = neg_d ? S_RECOMP : S_DONE;
                end
            end
            S_RECOMP: begin
                res_d   = {da_sum, res_q[W-1:DIG_W]};
                carry_d = da_cout;
                idx_d   = last ? '0 : idx_q + 1'b1;
                state_d = last ? S_DONE : S_RECOMP;
            end
            default: state_d = out_ready ? S_IDLE : S_DONE;
        endcase
    end
    always_comb begin
        in_ready  = state_q == S_IDLE;
        out_valid = state_q == S_DONE;
        out_sum   = out_valid ? res_q : '0;
        out_neg   = out_valid && neg_q;
        out_ovf   = out_valid && ovf_q;
        out_err   = out_valid && err_q;
        da_dig_a  = state_q == S_ADD ? a_q[DIG_W-1:0] : '0;
        da_dig_b  = state_q == S_ADD ? b_q[DIG_W-1:0] : state_q == S_RECOMP ? res_q[DIG_W-1:0] : '0;
        da_sub    = state_q == S_ADD ? sub_q : state_q == S_RECOMP;
        da_cin    = (state_q == S_ADD || state_q == S_RECOMP) && carry_q;
    end
endmodule
